cla16_mp_sequencer: RTL and testbench

Multi-precision add controller. Streams WORDS x 16-bit operand pairs through a single 16-bit carry-lookahead adder, one 16-bit word per cycle, least significant word first. A registered carry links the words. The block is a valid/ready slave on the command side and a valid/ready master on the result side. It lets wide (default 64-bit) additions share one CLA16 datapath instead of instantiating a full-width adder.

---
 rtl/cla_seq_pkg.sv | 23 ++
 rtl/cla16_mp_sequencer_cla16.sv | 65 ++++++
 rtl/cla16_mp_sequencer.sv | 144 ++++++++++++++
 tb/tb_cla16_mp_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// rtl/cla_seq_pkg.sv - shared constants, state encoding and index-width helper for the multi-precision CLA sequencer
package cla_seq_pkg;

    // Width of the shared carry-lookahead datapath
    localparam int CLA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ceiling log2 with a floor of one bit so a single-word build still has a legal index register
    function automatic int clog2(input int words);
        int w;
        w = 1;
        while ((1 << w) < words) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/cla16_mp_sequencer_cla16.sv
// rtl/cla16_mp_sequencer_cla16.sv - 16-bit carry-lookahead adder, four 4-bit groups with a lookahead carry unit
module cla16_mp_sequencer_cla16
    import cla_seq_pkg::*;
(
    input  logic [CLA_W-1:0] a_i,
    input  logic [CLA_W-1:0] b_i,
    input  logic             c_i,
    output logic [CLA_W-1:0] s_o,
    output logic             c_o
);

    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] p;
    logic [3:0]       grp_g;
    logic [3:0]       grp_p;
    logic [4:0]       grp_c;

    // Bit generate/propagate and per-group generate/propagate terms
    always_comb begin
        g     = a_i & b_i;
        p     = a_i ^ b_i;
        grp_g = '0;
        grp_p = '0;
        for (int k = 0; k < 4; k++) begin
            logic gk;
            logic pk;
            gk = 1'b0;
            pk = 1'b1;
            for (int i = 0; i < 4; i++) begin
                gk = g[4*k+i] | (p[4*k+i] & gk);
                pk = pk & p[4*k+i];
            end
            grp_g[k] = gk;
            grp_p[k] = pk;
        end
    end

    // Lookahead carry unit: every group carry-in is a flat function of c_i and the group terms
    always_comb begin
        grp_c[0] = c_i;
        grp_c[1] = grp_g[0] | (grp_p[0] & c_i);
        grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & c_i);
        grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & c_i);
        grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & c_i);
    end

    // Sum bits: carries inside each 4-bit group start from the lookahead group carry
    always_comb begin
        s_o = '0;
        for (int k = 0; k < 4; k++) begin
            logic cc;
            cc = grp_c[k];
            for (int i = 0; i < 4; i++) begin
                s_o[4*k+i] = p[4*k+i] ^ cc;
                cc = g[4*k+i] | (p[4*k+i] & cc);
            end
        end
    end

    assign c_o = grp_c[4];

endmodule

// File: rtl/cla16_mp_sequencer.sv
// rtl/cla16_mp_sequencer.sv - word-serial multi-precision adder around one CLA16; CLA_SEQ_SUB_EN adds a subtract mode
module cla16_mp_sequencer
    import cla_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [CLA_W*WORDS-1:0] a,
    input  logic [CLA_W*WORDS-1:0] b,
    input  logic                   carry_in,
`ifdef CLA_SEQ_SUB_EN
    input  logic                   sub,
`endif
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [CLA_W*WORDS-1:0] sum,
    output logic                   carry_out,
    output logic                   busy
);

    localparam int N  = CLA_W * WORDS;
    localparam int IW = clog2(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    state_e           state_q;
    state_e           state_d;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic [N-1:0]     sum_q;
    logic             cout_q;
`ifdef CLA_SEQ_SUB_EN
    logic             sub_q;
`endif

    logic             accept;
    logic             step;
    logic             last_word;
    logic             init_carry;
    int               word_base;
    logic [CLA_W-1:0] a_word;
    logic [CLA_W-1:0] b_word;
    logic [CLA_W-1:0] cla_sum;
    logic             cla_cout;

    // Word select for the current index; subtract mode feeds inverted B words
    always_comb begin
        word_base = int'(idx_q) * CLA_W;
        a_word    = a_q[word_base +: CLA_W];
`ifdef CLA_SEQ_SUB_EN
        b_word     = sub_q ? ~b_q[word_base +: CLA_W] : b_q[word_base +: CLA_W];
        init_carry = sub ? 1'b1 : carry_in;
`else
        b_word     = b_q[word_base +: CLA_W];
        init_carry = carry_in;
`endif
    end

    cla16_mp_sequencer_cla16 u_cla16 (
        .a_i (a_word),
        .b_i (b_word),
        .c_i (carry_q),
        .s_o (cla_sum),
        .c_o (cla_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes: accept only in IDLE, one word per RUN cycle, hold in DONE
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        step      = 1'b0;
        last_word = (idx_q == LAST_IDX);
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last_word) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latch, word-serial sum write-back and the carry chain between words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= init_carry;
            idx_q   <= '0;
`ifdef CLA_SEQ_SUB_EN
            sub_q   <= sub;
`endif
        end else if (step) begin
            sum_q[word_base +: CLA_W] <= cla_sum;
            carry_q                   <= cla_cout;
            idx_q                     <= last_word ? '0 : idx_q + IW'(1);
            if (last_word) begin
                cout_q <= cla_cout;
            end
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign res_valid   = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign sum         = sum_q;
    assign carry_out   = cout_q;

endmodule

// File: tb/tb_cla16_mp_sequencer.sv
// tb/tb_cla16_mp_sequencer.sv - scoreboard bench for cla16_mp_sequencer with a wide-arithmetic reference model
module tb_cla16_mp_sequencer;

    localparam int WORDS = 4;
    localparam int N     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         carry_in;
    logic         sub;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [N-1:0] sum;
    logic         carry_out;
    logic         busy;

    cla16_mp_sequencer #(.WORDS(WORDS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .carry_in    (carry_in),
`ifdef CLA_SEQ_SUB_EN
        .sub         (sub),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .carry_out   (carry_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] s;
        logic         c;
    } exp_t;

    exp_t q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   accept_cyc = 0;
    int   rr_mode    = 2;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       res_ready = 1'($urandom_range(0, 1));
            1:       res_ready = 1'b0;
            default: res_ready = 1'b1;
        endcase
    end

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                   input logic ci, input logic sv);
        exp_t r;
        logic [N:0] t;
        if (sv) begin
            r.s = av - bv;
            r.c = (av >= bv);
        end else begin
            t   = {1'b0, av} + {1'b0, bv} + (N+1)'(ci);
            r.s = t[N-1:0];
            r.c = t[N];
        end
        return r;
    endfunction

    logic         prev_v = 1'b0;
    logic [N-1:0] prev_sum;
    logic         prev_c;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (res_valid && !prev_v) chk("latency", N'(cyc - accept_cyc), N'(WORDS));
            if (res_valid && prev_v) begin
                chk("hold_sum", sum, prev_sum);
                chk("hold_cout", N'(carry_out), N'(prev_c));
            end
            if (res_valid && res_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%h required=none", sum);
                end else begin
                    e = q.pop_front();
                    chk("sum", sum, e.s);
                    chk("carry_out", N'(carry_out), N'(e.c));
                end
            end
            prev_v   = res_valid;
            prev_sum = sum;
            prev_c   = carry_out;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!start_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) begin
            checks++;
            failures++;
            $display("FAIL start_ready_timeout actual=0 required=1");
        end
    endtask

    task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic ci, input logic sv);
        @(posedge clk);
        #1;
        a = av; b = bv; carry_in = ci; sub = sv; start_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        q.push_back(model(av, bv, ci, sv));
        start_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rs;

        rst_n = 1'b0; start_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
        #12;
        chk("rst_res_valid", N'(res_valid), '0);
        chk("rst_busy", N'(busy), '0);
        chk("rst_start_ready", N'(start_ready), N'(1));
        chk("rst_sum", sum, '0);
        chk("rst_carry_out", N'(carry_out), '0);
        @(negedge clk);
        rst_n = 1'b1;

        send(64'h000A, 64'h0005, 1'b0, 1'b0);
        drain();
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        drain();
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        drain();
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        drain();

        rr_mode = 1;
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
        n = 0;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_res_valid", N'(res_valid), N'(1));
        @(posedge clk);
        #1;
        a = 64'hDEAD_BEEF_0000_FFFF; b = 64'h0000_0001_FFFF_0001; carry_in = 1'b0; sub = 1'b0;
        start_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("bp_start_ready", N'(start_ready), '0);
            chk("bp_busy", N'(busy), N'(1));
        end
        rr_mode = 2;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_ready", N'(start_ready), N'(1));
        chk("bp_idle_valid", N'(res_valid), '0);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        q.push_back(model(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b0, 1'b0));
        start_valid = 1'b0;
        drain();

        send(64'h5555_5555_5555_5555, 64'h3333_3333_3333_3333, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_res_valid", N'(res_valid), '0);
        chk("abort_busy", N'(busy), '0);
        chk("abort_start_ready", N'(start_ready), N'(1));
        chk("abort_sum", sum, '0);
        void'(q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        send(64'd1234, 64'd5662, 1'b0, 1'b0);
        drain();

`ifdef CLA_SEQ_SUB_EN
        send(64'd5, 64'd10, 1'b0, 1'b1);
        drain();
        send(64'd10, 64'd5, 1'b1, 1'b1);
        drain();
`endif

        rr_mode = 0;
        for (int i = 0; i < 30; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 5 == 1) rb = ~ra;
            if (i % 7 == 2) ra = 64'hFFFF_FFFF_FFFF_FFFF;
            rs = 1'b0;
`ifdef CLA_SEQ_SUB_EN
            rs = 1'($urandom_range(0, 1));
`endif
            send(ra, rb, 1'($urandom_range(0, 1)), rs);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
